// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP array types and pipeline constants
package dsp_pkg;

    // Activation width on the horizontal PE bus.
    localparam int HW_DSP_HOR_BUS_DW = 8;

    // Cycles from a PE left_in value to its effect in the PE psum register.
    // Both the PE and the row feeder default to this, so they stay aligned.
    localparam int DSP_PIPE_LAT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/skew_sreg.sv
// rtl/skew_sreg.sv - zero-resettable shift register used for per-row skew
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears every stage to zero
//   din  - value shifted into stage 0 each cycle
//   dout - last stage; din appears here DEPTH cycles later
module skew_sreg #(
    parameter int DW    = 8,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dsp_row_feeder.sv
// rtl/dsp_row_feeder.sv - skewing activation feeder and drain sequencer for the PE array
//
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset
//   s_valid      - input vector valid
//   s_ready      - feeder can accept a vector (low while draining)
//   s_data       - input vector, row r at [r*HOR_BUS_DW +: HOR_BUS_DW]
//   s_last       - vector is the last of the reduction tile
//   left_out     - skewed activations, row r delayed r+1 cycles from accept
//   psum_sel_out - per-row one-cycle drain select, skewed like the data
//   busy         - feeder is streaming or draining
//   tile_done    - one-cycle pulse in the final drain cycle
module dsp_row_feeder
    import dsp_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int HOR_BUS_DW = HW_DSP_HOR_BUS_DW,
    parameter int DSP_LAT    = DSP_PIPE_LAT,
    parameter int CNT_W      = $clog2(ROWS + DSP_LAT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [ROWS*HOR_BUS_DW-1:0] s_data,
    input  logic                       s_last,
    output logic [ROWS*HOR_BUS_DW-1:0] left_out,
    output logic [ROWS-1:0]            psum_sel_out,
    output logic                       busy,
    output logic                       tile_done
);

    localparam int DRAIN_CYCLES = ROWS + DSP_LAT;

    feeder_state_e state;
    logic [CNT_W-1:0] drain_cnt;
    logic accept;
    logic sel_seed;

    assign s_ready = (state != DRAIN);
    assign busy    = (state != IDLE);
    assign accept  = s_valid & s_ready;

    // drain_cnt is 0 in the first drain cycle (last accept + 1). Seeding the
    // pulse chain at DSP_LAT-1 puts row 0's select DSP_LAT cycles after its
    // last activation hit the array; the chain then adds one cycle per row,
    // matching the data skew. Assumes DSP_LAT >= 1.
    assign sel_seed = (state == DRAIN) && (drain_cnt == CNT_W'(DSP_LAT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            psum_sel_out <= '0;
            tile_done    <= 1'b0;
        end else begin
            tile_done    <= 1'b0;
            psum_sel_out <= {psum_sel_out[ROWS-2:0], sel_seed};
            case (state)
                IDLE: begin
                    drain_cnt <= '0;
                    if (accept) begin
                        state <= s_last ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (accept && s_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state     <= IDLE;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                    // Registered, so raised one count early to coincide with
                    // the final drain cycle and the last row's select.
                    if (drain_cnt == CNT_W'(DRAIN_CYCLES - 2)) begin
                        tile_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    drain_cnt <= '0;
                end
            endcase
        end
    end

    // Row r has depth r+1; non-accepted cycles feed zeros, which add nothing
    // to the accumulation and flush the skew by the end of the drain.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_sreg #(
            .DW   (HOR_BUS_DW),
            .DEPTH(r + 1)
        ) u_skew (
            .clk (clk),
            .rst (rst),
            .din (accept ? s_data[r*HOR_BUS_DW +: HOR_BUS_DW] : '0),
            .dout(left_out[r*HOR_BUS_DW +: HOR_BUS_DW])
        );
    end

endmodule

// File: tb/tb_dsp_row_feeder.sv
// tb/tb_dsp_row_feeder.sv - self-checking bench for dsp_row_feeder
module tb_dsp_row_feeder;

    localparam int R    = 4;
    localparam int DW   = 8;
    localparam int L    = 4;
    localparam int MAXC = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [R*DW-1:0] s_data;
    logic            s_last;
    logic [R*DW-1:0] left_out;
    logic [R-1:0]    psum_sel_out;
    logic            busy;
    logic            tile_done;

    always #5 clk = ~clk;

    dsp_row_feeder #(
        .ROWS      (R),
        .HOR_BUS_DW(DW),
        .DSP_LAT   (L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .left_out    (left_out),
        .psum_sel_out(psum_sel_out),
        .busy        (busy),
        .tile_done   (tile_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference history: what was accepted in each cycle.
    bit              acc [MAXC];
    bit              lst [MAXC];
    logic [R*DW-1:0] dat [MAXC];
    int cyc      = 0;
    int last_rst = -1;
    int last_acc = -1;
    bit checking = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One cycle: check outputs against the model, then drive and record inputs.
    task automatic run_cycle(input bit v, input logic [R*DW-1:0] d, input bit l, input bit r);
        logic [R*DW-1:0] exp_left;
        logic [R-1:0]    exp_sel;
        bit exp_done, exp_ready, exp_busy, in_drain, live;
        int t;
        @(negedge clk);
        exp_left = '0;
        exp_sel  = '0;
        exp_done = 0;
        for (int k = 0; k < R; k++) begin
            t = cyc - 1 - k;
            if (t >= 0 && t > last_rst && acc[t]) exp_left[k*DW +: DW] = dat[t][k*DW +: DW];
            t = cyc - 1 - k - L;
            if (t >= 0 && t > last_rst && acc[t] && lst[t]) exp_sel[k] = 1'b1;
        end
        t = cyc - R - L;
        if (t >= 0 && t > last_rst && acc[t] && lst[t]) exp_done = 1;
        live      = (last_acc > last_rst);
        in_drain  = live && lst[last_acc] && (cyc <= last_acc + R + L);
        exp_ready = !in_drain;
        exp_busy  = live && (!lst[last_acc] || cyc <= last_acc + R + L);
        if (checking) begin
            chk("left_out", 32'(left_out), 32'(exp_left));
            chk("psum_sel_out", 32'(psum_sel_out), 32'(exp_sel));
            chk("tile_done", 32'(tile_done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("s_ready", 32'(s_ready), 32'(exp_ready));
        end
        s_valid  = v;
        s_data   = d;
        s_last   = l;
        rst      = r;
        acc[cyc] = !r && v && exp_ready;
        lst[cyc] = l;
        dat[cyc] = d;
        if (r) begin
            last_rst = cyc;
            checking = 1;
        end
        if (acc[cyc]) last_acc = cyc;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, '0, 0, 0);
    endtask

    initial begin
        s_valid = 0;
        s_data  = '0;
        s_last  = 0;
        rst     = 1;
        run_cycle(0, '0, 0, 1);
        run_cycle(1, 32'hdeadbeef, 1, 1);
        idle(2);

        // Two-vector tile {1,2,3,4},{5,6,7,8}.
        run_cycle(1, {8'd4, 8'd3, 8'd2, 8'd1}, 0, 0);
        run_cycle(1, {8'd8, 8'd7, 8'd6, 8'd5}, 1, 0);
        idle(12);

        // Bubbles mid-tile.
        run_cycle(1, 32'h11223344, 0, 0);
        run_cycle(0, 32'hffffffff, 0, 0);
        run_cycle(0, 32'hffffffff, 1, 0);
        run_cycle(1, 32'h55667788, 1, 0);
        idle(12);

        // Single-vector tile.
        run_cycle(1, 32'ha1b2c3d4, 1, 0);
        idle(12);

        // s_valid held high through the drain with changing data.
        run_cycle(1, 32'h01020304, 1, 0);
        for (int i = 0; i < 10; i++) run_cycle(1, $urandom, 0, 0);
        idle(4);

        // Reset in drain cycle 2, then a nominal tile.
        run_cycle(1, 32'h0a0b0c0d, 0, 0);
        run_cycle(1, 32'h1a1b1c1d, 1, 0);
        run_cycle(0, '0, 0, 0);
        run_cycle(0, '0, 0, 1);
        idle(12);
        run_cycle(1, 32'h2a2b2c2d, 0, 0);
        run_cycle(1, 32'h3a3b3c3d, 1, 0);
        idle(12);

        // Back-to-back tiles, s_valid always high.
        for (int i = 0; i < 60; i++) run_cycle(1, $urandom, (i % 3) == 2, 0);
        idle(12);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            run_cycle(($urandom % 10) < 7, $urandom, ($urandom % 6) == 0, ($urandom % 100) == 0);
        end
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_row_feeder.md
# dsp_row_feeder

Upstream feeder for the DSP PE systolic array. It accepts one activation vector per cycle (one element per array row) over a valid/ready stream and skews the vector so row r is delayed r cycles. After the last vector of a reduction tile it injects zero bubbles and emits per-row, skewed `psum_sel` pulses timed to the PE pipeline. The array then drains each row's final accumulated psum downward on the vertical bus.

## Interface
- `ROWS`, 4: number of array rows fed (≥2).
- `HOR_BUS_DW`, `` `HW_DSP_HOR_BUS_DW `` (8): per-row activation width; matches the PE `left_in`.
- `DSP_LAT`, 4: cycles from a value on a PE `left_in` to that value's contribution being visible in the PE psum register.
- `CNT_W`, `$clog2(ROWS+DSP_LAT+1)`: drain counter width.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `s_valid`  in  1: input vector valid.
- `s_ready`  out  1: feeder can accept a vector.
- `s_data`  in  ROWS*HOR_BUS_DW: row r occupies bits [r*HOR_BUS_DW +: HOR_BUS_DW].
- `s_last`  in  1: this vector is the last of the reduction tile.
- `left_out`  out  ROWS*HOR_BUS_DW: skewed per-row activations to column 0 `left_in`.
- `psum_sel_out`  out  ROWS: per-row drain select to the PE `psum_sel`.
- `busy`  out  1: high in STREAM or DRAIN.
- `tile_done`  out  1: one-cycle pulse when a drain completes.

## Operation
- The FSM has three states: IDLE, STREAM and DRAIN.
  - IDLE → STREAM on the first accepted vector.
  - STREAM → DRAIN on an accepted vector with `s_last`=1. This includes a first vector with `s_last`=1, which goes IDLE → DRAIN directly.
  - DRAIN → IDLE after ROWS+DSP_LAT drain cycles.
- `s_ready`=1 in IDLE and STREAM and 0 in DRAIN. There is no internal FIFO; a vector is accepted when `s_valid & s_ready`.
- In STREAM, a cycle with `s_valid`=0 injects a zero vector. The accumulation is not disturbed because a zero activation adds 0.
- Skew is implemented as per-row shift registers. Row r has depth r+1, so every output is registered.
  - Input to row r is `s_data` row r on accept, else 0.
  - After draining, all shift stages hold 0.
- Drain pulses come from a ROWS-bit pulse shift chain seeded by the last-vector accept.
  - `psum_sel_out[r]` is high for exactly one cycle per tile.
- `tile_done` pulses in the final DRAIN cycle, which is also the cycle `psum_sel_out[ROWS-1]` is high.
- `busy` = (state != IDLE).
- Width rule: data passes through unmodified. There is no arithmetic on activations; the only arithmetic is the drain counter, which saturates at ROWS+DSP_LAT-1 and then clears.

## Timing
Cycle numbering: a vector accepted at the edge ending cycle T.
- Row r of that vector is on `left_out` in cycle T+1+r. Every accepted element reaches the array exactly once.
- For the last vector at T: `psum_sel_out[r]` is high in cycle T+1+r+DSP_LAT.
- `s_ready` is low in cycles T+1 … T+ROWS+DSP_LAT and high again in cycle T+ROWS+DSP_LAT+1.
- `tile_done` is high in cycle T+ROWS+DSP_LAT.
- Back-to-back tiles: the next tile's first element can be accepted in the cycle `s_ready` returns. There is no overlap with the previous drain.
- Reset (any state, including mid-DRAIN) takes effect at the next edge:
  - state = IDLE.
  - All skew stages, `left_out`, `psum_sel_out`, `tile_done` and `busy` = 0.
  - `s_ready` = 1 in the cycle after reset is sampled.
  - Any partially drained tile is discarded; no pulses resume.
- `s_valid` held high during DRAIN: nothing is accepted, and the data must be held by the source.

## Structure
- Shared package (`dsp_pkg`):
  - `feeder_state_e` enum {IDLE, STREAM, DRAIN}.
  - A `DSP_PIPE_LAT` constant (=4) used as the `DSP_LAT` default, so the feeder and PE stay consistent.
- Sub-module `skew_sreg #(DW, DEPTH)`: a zero-resettable shift register, instantiated once per row via generate.
- FSM, drain counter and pulse chain live in the top module.

## Test plan
- Single tile, ROWS=4, vectors {1,2,3,4},{5,6,7,8} (last) accepted at T=0,1:
  - row 2 shows 3 at cycle 3 and 7 at cycle 4.
  - `psum_sel_out` = 0001,0010,0100,1000 at cycles 6,7,8,9.
  - `tile_done` at cycle 9; `s_ready` high at cycle 10.
- Bubble insertion, `s_valid` low for 2 cycles mid-tile:
  - zeros appear on each row at the skewed positions.
  - drain timing is referenced only to the last accept.
- Single-vector tile (`s_last` on first accept at T=0):
  - IDLE → DRAIN.
  - `psum_sel_out[0]` at cycle 5; `tile_done` at cycle 8.
- `s_valid` held during DRAIN with changing data:
  - `s_ready`=0, nothing accepted, `left_out` carries only zeros after the skew empties.
- Reset asserted at drain cycle 2:
  - next cycle all outputs 0 and `s_ready`=1.
  - no further `psum_sel_out` pulses.
  - a new tile runs with nominal timing.
- Back-to-back tiles with `s_valid` always high:
  - exactly ROWS+DSP_LAT stall cycles between tiles.
  - per-row element count on `left_out` equals the number of accepted vectors.
